// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : Time-multiplexed 7-segment scan controller sharing one external
//           BCD_7SEG decoder across NUM_DIGITS common-anode digits, with a
//           blanking guard and a double-buffered frame.
//           Optional macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [7:0]              seg_in,
    output logic [3:0]              bcd,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int c_tmax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;
    localparam int c_iw   = $clog2(NUM_DIGITS);
    localparam int c_fw   = 4 * NUM_DIGITS;

    localparam logic [c_tw-1:0] c_show_last  = c_tw'(REFRESH_DIV - 1);
    localparam logic [c_tw-1:0] c_blank_last = c_tw'(BLANK_CYCLES - 1);
    localparam logic [c_iw-1:0] c_idx_last   = c_iw'(NUM_DIGITS - 1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [c_iw-1:0] idx_q,   idx_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic [c_fw-1:0] disp_q,  disp_d;
    logic [c_fw-1:0] pbuf_q,  pbuf_d;
    logic            pend_q,  pend_d;
    logic [3:0]      bcd_q,   bcd_d;

    logic w_show_end;
    logic w_frame_end;
    logic w_apply;
    logic w_lz_blank;

    function automatic logic [3:0] digit_sel(input logic [c_fw-1:0] frame,
                                             input logic [c_iw-1:0] sel);
        logic [3:0] d;
        d = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (c_iw'(k) == sel) begin
                d = frame[4*k +: 4];
            end
        end
        return d;
    endfunction

    assign w_show_end  = (state_q == c_st_show) && (timer_q == c_show_last);
    assign w_frame_end = w_show_end && (idx_q == c_idx_last);
    assign w_apply     = w_frame_end && pend_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_blank;
            idx_q   <= '0;
            timer_q <= '0;
            disp_q  <= '0;
            pbuf_q  <= '0;
            pend_q  <= 1'b0;
            bcd_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            disp_q  <= disp_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            bcd_q   <= bcd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        disp_d  = disp_q;
        pbuf_d  = pbuf_q;
        pend_d  = pend_q;
        bcd_d   = bcd_q;

        case (state_q)
            c_st_blank: begin
                if (timer_q == c_blank_last) begin
                    state_d = c_st_show;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (w_show_end) begin
                    state_d = c_st_blank;
                    timer_d = '0;
                    idx_d   = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
                    // Digit 0 of a new frame must come from the buffer being applied now
                    bcd_d   = digit_sel(w_apply ? pbuf_q : disp_q, idx_d);
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase

        if (w_apply) begin
            disp_d = pbuf_q;
            pend_d = 1'b0;
        end
        // A load coinciding with the apply only refills the pending buffer
        if (load) begin
            pbuf_d = din;
            pend_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Bit k set when digit k and every digit above it are zero
    logic [NUM_DIGITS-1:0] w_upper_zero;

    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NUM_DIGITS-1] = (disp_q[c_fw-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            w_upper_zero[k] = w_upper_zero[k+1] && (disp_q[4*k +: 4] == 4'h0);
        end
    end

    assign w_lz_blank = (idx_q != '0) && w_upper_zero[idx_q];
`else
    assign w_lz_blank = 1'b0;
`endif

    // Output logic
    always_comb begin
        an      = '1;
        seg_out = 8'h00;
        if ((state_q == c_st_show) && !w_lz_blank) begin
            an[idx_q] = 1'b0;
            seg_out   = seg_in;
        end
    end

    assign bcd        = bcd_q;
    assign frame_done = w_frame_end;
    assign pending    = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Directed self-checking bench for seg_scan_ctrl (4 digits,
//           REFRESH_DIV=4, BLANK_CYCLES=1, 20-cycle frame).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = NUM_DIGITS * (REFRESH_DIV + BLANK_CYCLES);
    localparam int SLOT         = REFRESH_DIV + BLANK_CYCLES;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic [7:0]  seg_in;
    logic [3:0]  bcd;
    logic [7:0]  seg_out;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    wire  [16:0] obs = {an, seg_out, bcd, frame_done};

    int checks   = 0;
    int failures = 0;
    int pos      = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (din),
        .seg_in    (seg_in),
        .bcd       (bcd),
        .seg_out   (seg_out),
        .an        (an),
        .frame_done(frame_done),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared external decoder
    function automatic logic [7:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;
            4'd1: return 8'h06;
            4'd2: return 8'h5B;
            4'd3: return 8'h4F;
            4'd4: return 8'h66;
            4'd5: return 8'h6D;
            4'd6: return 8'h7D;
            4'd7: return 8'h07;
            4'd8: return 8'h7F;
            4'd9: return 8'h6F;
            default: return {4'h8, d};
        endcase
    endfunction

    always_comb seg_in = dec(bcd);

    // Expected {an, seg_out, bcd, frame_done} at frame position p for display frame fr
    function automatic logic [16:0] exp_vec(input int p, input logic [15:0] fr);
        int         s;
        int         q;
        logic [3:0] d;
        logic [3:0] a;
        logic [7:0] sg;
        logic       lit;
        s  = p / SLOT;
        q  = p % SLOT;
        d  = fr[4*s +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lit = (s == 0) || ((fr >> (4*s)) != 16'h0);
`else
        lit = 1'b1;
`endif
        a  = 4'hF;
        sg = 8'h00;
        if (q != 0 && lit) begin
            a[s] = 1'b0;
            sg   = dec(d);
        end
        return {a, sg, d, (p == FRAME - 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic advance_to(input int p);
        for (int i = 0; i < FRAME && pos != p; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        din   = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== {4'hF, 8'h00, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, {4'hF, 8'h00, 4'h0, 1'b0});
        end
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending got=%b exp=0", pending);
        end
        load = 1'b0;
        din  = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pos = 0;
    endtask

    task automatic test_scan_timing();
        for (int c = 0; c < 2 * FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h0000)) begin
                failures++;
                $display("FAIL scan_timing pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h0000));
            end
            tick();
        end
    endtask

    task automatic test_double_buffer();
        advance_to(7);
        load = 1'b1;
        din  = 16'h4321;
        tick();
        load = 1'b0;
        while (pos != 0) begin
            checks++;
            if (pending !== 1'b1) begin
                failures++;
                $display("FAIL dbuf_pending pos=%0d got=%b exp=1", pos, pending);
            end
            checks++;
            if (obs !== exp_vec(pos, 16'h0000)) begin
                failures++;
                $display("FAIL dbuf_old_frame pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h0000));
            end
            tick();
        end
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL dbuf_applied got=%b exp=0", pending);
        end
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h4321)) begin
                failures++;
                $display("FAIL dbuf_frame pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h4321));
            end
            tick();
        end
    endtask

    task automatic test_last_load_wins();
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h4321)) begin
                failures++;
                $display("FAIL llw_hold pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h4321));
            end
            load = (pos == 3) || (pos == 10);
            din  = (pos == 3) ? 16'h1111 : 16'h9876;
            tick();
        end
        load = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h9876)) begin
                failures++;
                $display("FAIL llw_frame pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h9876));
            end
            tick();
        end
    endtask

    task automatic test_boundary_load();
        logic [15:0] fr_exp [4] = '{16'h9876, 16'h9876, 16'h5555, 16'h3333};
        logic [15:0] ld_val [4] = '{16'h5555, 16'h3333, 16'h0000, 16'h0000};
        logic        ld_en  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        pd_exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (pending !== pd_exp[f]) begin
                failures++;
                $display("FAIL bnd_pending frame=%0d got=%b exp=%b", f, pending, pd_exp[f]);
            end
            for (int c = 0; c < FRAME; c++) begin
                checks++;
                if (obs !== exp_vec(pos, fr_exp[f])) begin
                    failures++;
                    $display("FAIL bnd_frame f=%0d pos=%0d got=%h exp=%h", f, pos, obs, exp_vec(pos, fr_exp[f]));
                end
                load = ld_en[f] && (pos == FRAME - 1);
                din  = ld_val[f];
                tick();
            end
            load = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        advance_to(5);
        load = 1'b1;
        din  = 16'hABCD;
        tick();
        load = 1'b0;
        advance_to(12);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {4'hF, 8'h00, 4'h0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h exp=%h", obs, {4'hF, 8'h00, 4'h0, 1'b0});
        end
        checks++;
        if (pending !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_pending got=%b exp=0", pending);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        pos = 0;
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h0000)) begin
                failures++;
                $display("FAIL post_reset_frame pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h0000));
            end
            tick();
        end
    endtask

    task automatic test_leading_zero();
        load = 1'b1;
        din  = 16'h0070;
        tick();
        load = 1'b0;
        advance_to(0);
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (obs !== exp_vec(pos, 16'h0070)) begin
                failures++;
                $display("FAIL lz_frame pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos, 16'h0070));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        din   = 16'h0000;
        test_reset();
        test_scan_timing();
        test_double_buffer();
        test_last_load_wins();
        test_boundary_load();
        test_async_reset();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
